// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: start/IR inputs and datapath control outputs of the hardwired sequencer
interface alu_ctrl_seq_if;
  logic start;
  logic [31:0] IR;
  logic PCout, PCin, IncPC, MARin;
  logic Read, MDRin, MDRout;
  logic IRin, Yin, Zin, Zhighout, Zlowout, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout;
  logic [4:0] opcode;
  logic run, fault;
  logic [3:0] state;
  modport master (
    input start, IR,
    output PCout, PCin, IncPC, MARin, Read, MDRin, MDRout,
    output IRin, Yin, Zin, Zhighout, Zlowout, HIin, LOin,
    output Gra, Grb, Grc, Rin, Rout, opcode, run, fault, state
  );
  modport slave (
    output start, IR,
    input PCout, PCin, IncPC, MARin, Read, MDRin, MDRout,
    input IRin, Yin, Zin, Zhighout, Zlowout, HIin, LOin,
    input Gra, Grb, Grc, Rin, Rout, opcode, run, fault, state
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: hardwired T0-T6 control sequencer for fetch and register-format ALU instructions
module alu_ctrl_seq (
  input logic Clock,
  input logic clear,
  alu_ctrl_seq_if.master b
);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT, FAULT} state_t;
  state_t s, ns;
  logic [4:0] op;
  logic bin, md, un, bm;
  assign op = b.IR[31:27];
  assign bin = op >= 5'b00011 && op <= 5'b01011;
  assign md = op == 5'b01111 || op == 5'b10000;
  assign un = op == 5'b10001 || op == 5'b10010;
  assign bm = bin || md;
  always_ff @(posedge Clock) s <= clear ? IDLE : ns;
  always_comb begin
    ns = s;
    case (s)
      IDLE: ns = b.start ? T0 : IDLE;
      T0: ns = T1;
      T1: ns = T2;
      T2: ns = T3;
      T3: ns = (bm || un) ? T4 : op == 5'b11010 ? T0 : op == 5'b11011 ? HALT : FAULT;
      T4: ns = bm ? T5 : T0;
      T5: ns = md ? T6 : T0;
      T6: ns = T0;
      HALT: ns = b.start ? T0 : HALT;
      default: ns = FAULT;
    endcase
  end
  // IR only matters from T3 on; fetch states decode purely from the state
  always_comb begin
    b.PCout = s == T0;
    b.MARin = s == T0;
    b.IncPC = s == T0;
    b.Zin = s == T0 || (s == T4 && bm) || (s == T3 && un);
    b.PCin = s == T1;
    b.Read = s == T1;
    b.MDRin = s == T1;
    b.Zlowout = s == T1 || (s == T5 && bm) || (s == T4 && un);
    b.MDRout = s == T2;
    b.IRin = s == T2;
    b.Yin = s == T3 && bm;
    b.Grb = s == T3 && (bm || un);
    b.Rout = (s == T3 && (bm || un)) || (s == T4 && bm);
    b.Grc = s == T4 && bm;
    b.Gra = (s == T5 && bin) || (s == T4 && un);
    b.Rin = (s == T5 && bin) || (s == T4 && un);
    b.LOin = s == T5 && md;
    b.Zhighout = s == T6 && md;
    b.HIin = s == T6 && md;
    b.opcode = ((s == T4 && bm) || (s == T3 && un)) ? op : 5'b00000;
    b.run = s >= T0 && s <= T6;
    b.fault = s == FAULT;
    b.state = s;
  end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: table-driven per-cycle check of states and control outputs via a scoreboard queue
module tb_alu_ctrl_seq;
  logic Clock = 1'b0;
  logic clear = 1'b1;
  always #5 Clock = ~Clock;
  alu_ctrl_seq_if b();
  alu_ctrl_seq dut (.Clock(Clock), .clear(clear), .b(b.master));
  typedef struct {
    logic clr;
    logic st;
    logic [31:0] ir;
    logic [3:0] s;
    logic [18:0] c;
    logic [4:0] op;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  localparam logic [18:0] PCOUT = 19'h40000, PCIN = 19'h20000, INCPC = 19'h10000, MARIN = 19'h08000;
  localparam logic [18:0] READ = 19'h04000, MDRIN = 19'h02000, MDROUT = 19'h01000, IRIN = 19'h00800;
  localparam logic [18:0] YIN = 19'h00400, ZIN = 19'h00200, ZHI = 19'h00100, ZLO = 19'h00080;
  localparam logic [18:0] HIIN = 19'h00040, LOIN = 19'h00020, GRA = 19'h00010, GRB = 19'h00008;
  localparam logic [18:0] GRC = 19'h00004, RIN = 19'h00002, ROUT = 19'h00001;
  localparam logic [18:0] E_T0 = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [18:0] E_T1 = ZLO | PCIN | READ | MDRIN;
  localparam logic [18:0] E_T2 = MDROUT | IRIN;
  localparam logic [18:0] E_B3 = GRB | ROUT | YIN;
  localparam logic [18:0] E_B4 = GRC | ROUT | ZIN;
  localparam logic [18:0] E_B5 = ZLO | GRA | RIN;
  localparam logic [18:0] E_M5 = ZLO | LOIN;
  localparam logic [18:0] E_M6 = ZHI | HIIN;
  localparam logic [18:0] E_U3 = GRB | ROUT | ZIN;
  localparam logic [18:0] E_U4 = ZLO | GRA | RIN;
  localparam logic [31:0] I_AND = 32'h28918000, I_ROR = 32'h50000000, I_MUL = 32'h78000000;
  localparam logic [31:0] I_NOT = 32'h90000000, I_NOP = 32'hD0000000, I_HALT = 32'hD8000000;
  localparam logic [31:0] I_ILL = 32'hF8000000, I_ADD = 32'h18000000;
  logic [18:0] ctl;
  assign ctl = {b.PCout, b.PCin, b.IncPC, b.MARin, b.Read, b.MDRin, b.MDRout, b.IRin, b.Yin, b.Zin,
                b.Zhighout, b.Zlowout, b.HIin, b.LOin, b.Gra, b.Grb, b.Grc, b.Rin, b.Rout};
  function automatic void add_v(input logic clr, input logic st, input logic [31:0] ir,
                                input logic [3:0] s, input logic [18:0] c, input logic [4:0] op);
    vec_t v;
    v.clr = clr;
    v.st = st;
    v.ir = ir;
    v.s = s;
    v.c = c;
    v.op = op;
    vecs.push_back(v);
  endfunction
  // one instruction from T0: fetch cycles, class-specific execute cycles, then next T0 or stop state
  function automatic void ins(input logic [31:0] ir, input logic [4:0] opc, input int kind);
    add_v(1'b0, 1'b0, ir, 4'd2, E_T1, 5'd0);
    add_v(1'b0, 1'b1, ir, 4'd3, E_T2, 5'd0);
    case (kind)
      0: begin
        add_v(1'b0, 1'b0, ir, 4'd4, E_B3, 5'd0);
        add_v(1'b0, 1'b0, ir, 4'd5, E_B4, opc);
        add_v(1'b0, 1'b0, ir, 4'd6, E_B5, 5'd0);
        add_v(1'b0, 1'b0, ir, 4'd1, E_T0, 5'd0);
      end
      1: begin
        add_v(1'b0, 1'b0, ir, 4'd4, E_B3, 5'd0);
        add_v(1'b0, 1'b0, ir, 4'd5, E_B4, opc);
        add_v(1'b0, 1'b0, ir, 4'd6, E_M5, 5'd0);
        add_v(1'b0, 1'b0, ir, 4'd7, E_M6, 5'd0);
        add_v(1'b0, 1'b0, ir, 4'd1, E_T0, 5'd0);
      end
      2: begin
        add_v(1'b0, 1'b0, ir, 4'd4, E_U3, opc);
        add_v(1'b0, 1'b0, ir, 4'd5, E_U4, 5'd0);
        add_v(1'b0, 1'b0, ir, 4'd1, E_T0, 5'd0);
      end
      3: begin
        add_v(1'b0, 1'b0, ir, 4'd4, 19'd0, 5'd0);
        add_v(1'b0, 1'b0, ir, 4'd1, E_T0, 5'd0);
      end
      4: begin
        add_v(1'b0, 1'b0, ir, 4'd4, 19'd0, 5'd0);
        add_v(1'b0, 1'b0, ir, 4'd8, 19'd0, 5'd0);
      end
      default: begin
        add_v(1'b0, 1'b0, ir, 4'd4, 19'd0, 5'd0);
        add_v(1'b0, 1'b0, ir, 4'd9, 19'd0, 5'd0);
      end
    endcase
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL v%0d %s: got %h, want %h", n_vec, nm, act, exp);
    end
  endtask
  task automatic step(input vec_t v);
    vec_t e;
    clear = v.clr;
    b.start = v.st;
    b.IR = v.ir;
    sb.push_back(v);
    @(posedge Clock);
    #1;
    e = sb.pop_front();
    n_vec++;
    check("state", 32'(b.state), 32'(e.s));
    check("ctrl", 32'(ctl), 32'(e.c));
    check("opcode", 32'(b.opcode), 32'(e.op));
    check("run", 32'(b.run), 32'(e.s >= 4'd1 && e.s <= 4'd7));
    check("fault", 32'(b.fault), 32'(e.s == 4'd9));
  endtask
  task automatic run_table();
    vec_t v;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      step(v);
    end
  endtask
  initial begin
    b.start = 1'b0;
    b.IR = 32'd0;
    add_v(1'b1, 1'b1, I_AND, 4'd0, 19'd0, 5'd0);
    add_v(1'b1, 1'b1, I_AND, 4'd0, 19'd0, 5'd0);
    add_v(1'b0, 1'b1, I_AND, 4'd1, E_T0, 5'd0);
    ins(I_AND, 5'b00101, 0);
    ins(I_ROR, 5'b01010, 0);
    ins(I_MUL, 5'b01111, 1);
    ins(I_NOT, 5'b10010, 2);
    ins(I_NOP, 5'd0, 3);
    ins(I_HALT, 5'd0, 4);
    run_table();
    for (int i = 0; i < 10; i++) add_v(1'b0, 1'b0, I_ILL, 4'd8, 19'd0, 5'd0);
    add_v(1'b0, 1'b1, I_ILL, 4'd1, E_T0, 5'd0);
    run_table();
    ins(I_ILL, 5'd0, 5);
    add_v(1'b0, 1'b1, I_ILL, 4'd9, 19'd0, 5'd0);
    add_v(1'b0, 1'b1, I_ILL, 4'd9, 19'd0, 5'd0);
    add_v(1'b1, 1'b0, I_ILL, 4'd0, 19'd0, 5'd0);
    add_v(1'b1, 1'b1, I_ADD, 4'd0, 19'd0, 5'd0);
    add_v(1'b0, 1'b1, I_ADD, 4'd1, E_T0, 5'd0);
    run_table();
    add_v(1'b0, 1'b0, I_ADD, 4'd2, E_T1, 5'd0);
    add_v(1'b0, 1'b0, I_ADD, 4'd3, E_T2, 5'd0);
    add_v(1'b0, 1'b0, I_ADD, 4'd4, E_B3, 5'd0);
    add_v(1'b0, 1'b0, I_ADD, 4'd5, E_B4, 5'b00011);
    add_v(1'b1, 1'b0, I_ADD, 4'd0, 19'd0, 5'd0);
    add_v(1'b0, 1'b0, I_ADD, 4'd0, 19'd0, 5'd0);
    add_v(1'b0, 1'b0, I_ADD, 4'd0, 19'd0, 5'd0);
    run_table();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Hardwired control sequencer for the datapath's fetch and register-format ALU instructions. It generates the per-cycle register enables, bus-driver selects, memory strobes and ALU opcode that testbenches currently drive by hand through states T0–T6. It sits beside the datapath, reads the IR contents back, and drives the datapath control ports and the select-and-encode inputs (Gra/Grb/Grc, Rin/Rout).

## Interface
- No parameters; the state encoding and opcode map are fixed below.
- Clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle pulse; leaves IDLE or HALT.
- IR  in  32  datapath IR contents. Opcode is IR[31:27]; Ra/Rb/Rc fields are decoded downstream by select-and-encode.
- PCout, PCin, IncPC, MARin  out  1 each  PC/MAR controls.
- Read, MDRin, MDRout  out  1 each  memory read strobe and MDR controls.
- IRin, Yin, Zin, Zhighout, Zlowout, HIin, LOin  out  1 each  register enables and bus drivers.
- Gra, Grb, Grc, Rin, Rout  out  1 each  select-and-encode controls.
- opcode  out  5  ALU operation.
- run  out  1  high in every state except IDLE, HALT and FAULT.
- fault  out  1  high in FAULT.
- state  out  4  current state, for debug.

## Operation
- State encoding: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8, FAULT=9. Each state lasts exactly one cycle, except IDLE, HALT and FAULT.
- All outputs are a combinational decode of the registered state plus IR[31:27]. An output not listed for a state is 0.
- IDLE: no outputs asserted. On start, go to T0.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin. A memory read completes within this cycle.
- T2: MDRout, IRin. The IR is valid from T3 onward.
- Opcode classes, taken from IR[31:27]:
  - Binary: add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011.
  - mul/div: mul 01111, div 10000.
  - Unary: neg 10001, not 10010.
  - Control: nop 11010, halt 11011.
  - Any other value is illegal.
- Binary sequence:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, opcode=IR[31:27].
  - T5: Zlowout, Gra, Rin; next state T0.
- mul/div sequence:
  - T3 and T4 as for binary.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin; next state T0.
- Unary sequence:
  - T3: Grb, Rout, Zin, opcode=IR[31:27].
  - T4: Zlowout, Gra, Rin; next state T0.
- Control sequence:
  - nop: T3 has no outputs; next state T0.
  - halt: T3 goes to HALT.
- Illegal opcode: T3 goes to FAULT.
- opcode is 5'b00000 in every state where Zin is not asserted for an ALU op. In T0, Zin is asserted with opcode 00000; the datapath's IncPC path handles that case.
- HALT: start goes to T0. The PC was already incremented in T0/T1, so execution resumes at the next instruction.
- FAULT: held until clear; start is ignored.

## Timing
- Reset: clear high at any rising edge sets state=IDLE, with effect from the next cycle.
  - All outputs are 0 in IDLE (run=0, fault=0, opcode=0).
  - clear has priority over start and over any in-flight sequence.
  - A partially executed instruction is abandoned; there is no writeback.
- Instruction latency in cycles, T0 to the next T0:
  - binary: 6.
  - mul/div: 7.
  - unary: 5.
  - nop: 4.
  - halt: 4 to HALT.
- start outside IDLE/HALT is ignored. start in the same cycle as clear is ignored.
- In each state, the bus driver and its destination enable are asserted together for the whole cycle. No state drives two bus sources.
- IR is sampled combinationally in T3..T6 only. IR changes during T0–T2 have no effect.

## Test plan
- Reset: hold clear for 2 cycles with start=1 -> state=0, every output 0. Release clear and pulse start -> T0 on the next edge, with PCout=MARin=IncPC=Zin=1.
- and R1,R2,R3 (IR=0x28918000) -> exact sequence T0..T5:
  - T3: Grb/Rout/Yin.
  - T4: Grc/Rout/Zin, opcode=00101.
  - T5: Zlowout/Gra/Rin.
  - Then T0 again: 6 cycles per instruction, run=1 throughout.
- ror (opcode 01010) then mul (opcode 01111) back-to-back:
  - ror: T4 opcode=01010.
  - mul: T5 LOin with Zlowout, T6 HIin with Zhighout, 7 cycles.
  - No Rin during mul.
- not (10010): T3 has Rout+Zin with opcode=10010 and Yin=0; T4 Gra/Rin; 5 cycles. nop (11010): T3 has no outputs; back to T0 after 4 cycles.
- halt (11011) -> HALT, run=0.
  - Holding start=0 for 10 cycles leaves it stalled.
  - A start pulse -> T0.
  - Illegal opcode 11111 -> FAULT, fault=1; start is ignored; clear -> IDLE with fault=0.
- clear asserted during T4 of an add -> state=0 the next cycle; Rin is never asserted for that instruction.
